// File: rtl/tx_stats_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tx_stats_pkg
// Description : Shared constants, types and the frame-size bin decoder used by
//               the TX statistics accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package tx_stats_pkg;

    localparam int LEN_WIDTH  = 14;
    localparam int ADDR_WIDTH = 4;
    localparam int NUM_BINS   = 8;
    localparam int NUM_CNT    = 2 + NUM_BINS;

    localparam logic [ADDR_WIDTH-1:0] ADDR_FRAMES = 4'd0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_OCTETS = 4'd1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_BIN0   = 4'd2;
    localparam logic [ADDR_WIDTH-1:0] ADDR_BIN1   = 4'd3;
    localparam logic [ADDR_WIDTH-1:0] ADDR_BIN2   = 4'd4;
    localparam logic [ADDR_WIDTH-1:0] ADDR_BIN3   = 4'd5;
    localparam logic [ADDR_WIDTH-1:0] ADDR_BIN4   = 4'd6;
    localparam logic [ADDR_WIDTH-1:0] ADDR_BIN5   = 4'd7;
    localparam logic [ADDR_WIDTH-1:0] ADDR_BIN6   = 4'd8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_BIN7   = 4'd9;

    localparam logic [LEN_WIDTH-1:0] BIN_TH_64   = 14'd64;
    localparam logic [LEN_WIDTH-1:0] BIN_TH_127  = 14'd127;
    localparam logic [LEN_WIDTH-1:0] BIN_TH_255  = 14'd255;
    localparam logic [LEN_WIDTH-1:0] BIN_TH_511  = 14'd511;
    localparam logic [LEN_WIDTH-1:0] BIN_TH_1023 = 14'd1023;
    localparam logic [LEN_WIDTH-1:0] BIN_TH_1518 = 14'd1518;

    typedef logic [2:0] bin_idx_t;

    // Exactly 64 octets gets its own bin; everything below it lands in bin 0.
    function automatic bin_idx_t bin_of(input logic [LEN_WIDTH-1:0] len);
        if (len < BIN_TH_64)
            return 3'd0;
        else if (len == BIN_TH_64)
            return 3'd1;
        else if (len <= BIN_TH_127)
            return 3'd2;
        else if (len <= BIN_TH_255)
            return 3'd3;
        else if (len <= BIN_TH_511)
            return 3'd4;
        else if (len <= BIN_TH_1023)
            return 3'd5;
        else if (len <= BIN_TH_1518)
            return 3'd6;
        else
            return 3'd7;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stat_counter.sv
`default_nettype none
// ============================================================================
// Module      : stat_counter
// Description : One statistics counter: optional clear, then add, with either
//               modulo wrap or saturation at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module stat_counter #(
    parameter int CNT_WIDTH = 32,
    parameter int INC_WIDTH = 14,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc_en,
    input  logic [INC_WIDTH-1:0] inc,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int SUM_WIDTH = ((CNT_WIDTH > INC_WIDTH) ? CNT_WIDTH : INC_WIDTH) + 1;
    localparam logic [CNT_WIDTH-1:0] c_max = '1;

    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_base;
    logic [CNT_WIDTH-1:0] w_next;
    logic [SUM_WIDTH-1:0] w_sum;

    // A clear coinciding with an increment keeps the increment, so no count is lost.
    always_comb begin
        w_base = clr ? '0 : r_count;
        w_sum  = SUM_WIDTH'(w_base) + SUM_WIDTH'(inc);
        w_next = w_base;
        if (inc_en) begin
            if ((SATURATE != 0) && (w_sum > SUM_WIDTH'(c_max)))
                w_next = c_max;
            else
                w_next = w_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else
            r_count <= w_next;
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/tx_stats_accum.sv
`default_nettype none
// ============================================================================
// Module      : tx_stats_accum
// Description : Accumulates TX frame count, octet count and an 8-bin size
//               histogram from the TX statistics FIFO; single-cycle read port.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_stats_accum
    import tx_stats_pkg::*;
#(
    parameter int CNT_WIDTH     = 32,
    parameter int CLEAR_ON_READ = 0,
    parameter int SATURATE      = 0
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [LEN_WIDTH-1:0]  txsfifo_rdata,
    input  logic                  txsfifo_rempty,
    input  logic                  stat_rd,
    input  logic [ADDR_WIDTH-1:0] stat_addr,
    input  logic                  clear_all,
    output logic [CNT_WIDTH-1:0]  stat_rdata,
    output logic                  stat_rvalid
);

    logic                 r_v1;
    logic [LEN_WIDTH-1:0] r_len;
    bin_idx_t             r_bin;

    logic [NUM_CNT-1:0]   w_clr;
    logic [CNT_WIDTH-1:0] w_count [NUM_CNT];
    logic [CNT_WIDTH-1:0] w_rd_data;

    // Stage 1: capture the FIFO entry and its size bin every cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_v1  <= 1'b0;
            r_len <= '0;
            r_bin <= '0;
        end else begin
            r_v1  <= ~txsfifo_rempty;
            r_len <= txsfifo_rdata;
            r_bin <= bin_of(txsfifo_rdata);
        end
    end

    // Stage 2: one counter per address; each applies its own clear and increment.
    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        logic [LEN_WIDTH-1:0] w_inc;
        logic                 w_en;

        if (i == int'(ADDR_OCTETS)) begin : g_octets
            assign w_inc = r_len;
            assign w_en  = r_v1;
        end else if (i == int'(ADDR_FRAMES)) begin : g_frames
            assign w_inc = LEN_WIDTH'(1);
            assign w_en  = r_v1;
        end else begin : g_bin
            assign w_inc = LEN_WIDTH'(1);
            assign w_en  = r_v1 && (r_bin == bin_idx_t'(i - int'(ADDR_BIN0)));
        end

        assign w_clr[i] = clear_all ||
                          ((CLEAR_ON_READ != 0) && stat_rd && (stat_addr == ADDR_WIDTH'(i)));

        stat_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .INC_WIDTH (LEN_WIDTH),
            .SATURATE  (SATURATE)
        ) u_cnt (
            .clk    (wb_clk_i),
            .rst    (wb_rst_i),
            .clr    (w_clr[i]),
            .inc_en (w_en),
            .inc    (w_inc),
            .count  (w_count[i])
        );
    end

    // Unmapped addresses read as zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (stat_addr == ADDR_WIDTH'(i))
                w_rd_data = w_count[i];
        end
    end

    // Counter outputs are pre-update state, so a read never sees this cycle's increment.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            stat_rvalid <= 1'b0;
            stat_rdata  <= '0;
        end else begin
            stat_rvalid <= stat_rd;
            if (stat_rd)
                stat_rdata <= w_rd_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_stats_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_stats_accum
// Description : Scoreboard bench for three configurations of tx_stats_accum
//               sharing one stimulus stream, checked against a counter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_stats_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] rdata = '0;
    logic        rempty = 1'b1;
    logic        rd = 1'b0;
    logic [3:0]  addr = '0;
    logic        clr_all = 1'b0;

    logic [31:0] rdata0;
    logic [7:0]  rdata1;
    logic [7:0]  rdata2;
    logic        rvalid0, rvalid1, rvalid2;

    int ntot = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    tx_stats_accum #(.CNT_WIDTH(32), .CLEAR_ON_READ(0), .SATURATE(0)) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .txsfifo_rdata(rdata), .txsfifo_rempty(rempty),
        .stat_rd(rd), .stat_addr(addr), .clear_all(clr_all),
        .stat_rdata(rdata0), .stat_rvalid(rvalid0));

    tx_stats_accum #(.CNT_WIDTH(8), .CLEAR_ON_READ(1), .SATURATE(1)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .txsfifo_rdata(rdata), .txsfifo_rempty(rempty),
        .stat_rd(rd), .stat_addr(addr), .clear_all(clr_all),
        .stat_rdata(rdata1), .stat_rvalid(rvalid1));

    tx_stats_accum #(.CNT_WIDTH(8), .CLEAR_ON_READ(0), .SATURATE(0)) dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .txsfifo_rdata(rdata), .txsfifo_rempty(rempty),
        .stat_rd(rd), .stat_addr(addr), .clear_all(clr_all),
        .stat_rdata(rdata2), .stat_rvalid(rvalid2));

    // ---------------- reference model ----------------
    int     cfg_cw  [3] = '{32, 8, 8};
    bit     cfg_cor [3] = '{1'b0, 1'b1, 1'b0};
    bit     cfg_sat [3] = '{1'b0, 1'b1, 1'b0};
    int     bin_ub  [8] = '{63, 64, 127, 255, 511, 1023, 1518, 16383};
    longint m_cnt   [3][10];
    longint q0[$], q1[$], q2[$];

    function automatic int size_bin(input int len);
        for (int b = 0; b < 8; b++)
            if (len <= bin_ub[b]) return b;
        return 7;
    endfunction

    task automatic push_exp(input int k, input longint v);
        case (k)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    initial begin : model
        bit     pend_v;
        int     pend_len;
        longint base, inc, v, mx;
        pend_v = 1'b0;
        pend_len = 0;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 10; i++) m_cnt[k][i] = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int k = 0; k < 3; k++)
                    for (int i = 0; i < 10; i++) m_cnt[k][i] = 0;
                pend_v = 1'b0;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    mx = (64'sd1 <<< cfg_cw[k]) - 1;
                    if (rd) push_exp(k, (int'(addr) < 10) ? m_cnt[k][addr] : 0);
                    for (int i = 0; i < 10; i++) begin
                        base = (clr_all || (cfg_cor[k] && rd && int'(addr) == i)) ? 0 : m_cnt[k][i];
                        inc = 0;
                        if (pend_v) begin
                            if (i == 0) inc = 1;
                            else if (i == 1) inc = pend_len;
                            else if (i == 2 + size_bin(pend_len)) inc = 1;
                        end
                        v = base + inc;
                        if (cfg_sat[k] && v > mx) v = mx;
                        else v = v % (mx + 1);
                        m_cnt[k][i] = v;
                    end
                end
                pend_v = !rempty;
                pend_len = int'(rdata);
            end
        end
    end

    // ---------------- monitor ----------------
    task automatic chk_read(input int k, input logic v, input longint act);
        longint exp;
        int     sz;
        if (v) begin
            ntot++;
            sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
            if (sz == 0) begin
                nbad++;
                $display("FAIL unexpected_rvalid dut%0d: got rdata=%0d expected no response", k, act);
            end else begin
                exp = (k == 0) ? q0.pop_front() : (k == 1) ? q1.pop_front() : q2.pop_front();
                if (act != exp) begin
                    nbad++;
                    $display("FAIL rdata dut%0d: got %0d expected %0d", k, act, exp);
                end
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            chk_read(0, rvalid0, longint'(rdata0));
            chk_read(1, rvalid1, longint'(rdata1));
            chk_read(2, rvalid2, longint'(rdata2));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input int len, input bit r, input int a, input bit ca);
        rempty  = !v;
        rdata   = 14'(len);
        rd      = r;
        addr    = 4'(a);
        clr_all = ca;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic rd_addr(input int a);
        step(0, 0, 1, a, 0);
    endtask

    task automatic chk_reset_out();
        ntot++;
        if (rvalid0 || rvalid1 || rvalid2 || rdata0 != 0 || rdata1 != 0 || rdata2 != 0) begin
            nbad++;
            $display("FAIL reset_outputs: got rvalid=%b%b%b rdata=%0d/%0d/%0d expected all 0",
                     rvalid0, rvalid1, rvalid2, rdata0, rdata1, rdata2);
        end
    endtask

    int lens2 [5] = '{60, 65, 1518, 1519, 0};
    int edges [15] = '{0, 63, 64, 65, 127, 128, 255, 256, 511, 512, 1023, 1024, 1518, 1519, 16383};

    initial begin : stim
        @(negedge clk);
        idle(3);
        chk_reset_out();
        rst = 1'b0;
        idle(2);

        // single 64-octet entry, then read every counter plus an unmapped address
        step(1, 64, 0, 0, 0);
        idle(2);
        for (int a = 0; a < 10; a++) rd_addr(a);
        rd_addr(12);
        idle(1);

        // back-to-back boundary lengths
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, lens2[i], 0, 0, 0);
        idle(2);
        for (int a = 0; a < 10; a++) rd_addr(a);

        // read of frames coincident with a stage-2 update
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 100, 0, 0, 0);
        idle(2);
        step(1, 100, 0, 0, 0);
        rd_addr(0);
        idle(1);
        rd_addr(0);
        rd_addr(4);

        // clear_all coincident with an update and an octet read
        step(1, 200, 0, 0, 0);
        step(0, 0, 1, 1, 1);
        idle(1);
        rd_addr(1);
        rd_addr(0);
        rd_addr(5);

        // saturation / wrap over 300 entries
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 300; i++) step(1, 64, 0, 0, 0);
        idle(2);
        rd_addr(0);
        rd_addr(1);
        rd_addr(3);

        // one-cycle reset in the middle of a stream
        for (int i = 0; i < 6; i++) step(1, 100 + i, 0, 0, 0);
        rst = 1'b1;
        step(1, 300, 0, 0, 0);
        chk_reset_out();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1, 1000 + i, 0, 0, 0);
        idle(2);
        for (int a = 0; a < 10; a++) rd_addr(a);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            bit v, r, ca;
            int len;
            v   = ($urandom_range(0, 3) != 0);
            len = ($urandom_range(0, 1) != 0) ? edges[$urandom_range(0, 14)]
                                              : int'($urandom_range(0, 16383));
            r   = ($urandom_range(0, 3) == 0);
            ca  = ($urandom_range(0, 63) == 0);
            step(v, len, r, int'($urandom_range(0, 15)), ca);
        end
        idle(2);
        for (int a = 0; a < 16; a++) rd_addr(a);
        idle(3);

        ntot++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            nbad++;
            $display("FAIL missing_responses: got %0d outstanding expected 0",
                     q0.size() + q1.size() + q2.size());
        end
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: got no completion expected finish before limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
